// File: rtl/button_press_decoder_pkg.sv
// Shared game definitions: button count, button index/vector types and the
// press-event helpers used by the decoder, the game FSM and the LED logic.
package button_press_decoder_pkg;

  localparam int NUM_BUTTONS = 4;

  typedef logic [1:0]             btn_idx_t;
  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  // Lowest-numbered set button wins.
  function automatic btn_idx_t lowest_idx(input btn_vec_t v);
    btn_idx_t idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi(input btn_vec_t v);
    return |(v & (v - 4'd1));
  endfunction

endpackage

// File: rtl/button_press_decoder_debounce_cell.sv
// One button: synchronizer, stability counter and debounced level. The rise
// strobe fires on the same edge that the level flips from 0 to 1.
module debounce_cell #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic                   level_r;
  logic                   s_s;
  logic                   flip_s;

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign flip_s = (s_s != level_r) && (cnt_r == CNT_LAST);
  assign rise   = flip_s && !level_r;
  assign level  = level_r;

  // Metastability synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  // Level only follows the synchronized input after it has disagreed for a full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (s_s == level_r) begin
      cnt_r   <= '0;
      level_r <= level_r;
    end else if (flip_s) begin
      cnt_r   <= '0;
      level_r <= s_s;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
      level_r <= level_r;
    end
  end

endmodule

// File: rtl/button_press_decoder.sv
// Debounces the four game buttons and turns each clean press into a single
// index event held for the game FSM under a valid/ready handshake.
module button_press_decoder
  import button_press_decoder_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   enable,
  input  logic                   press_ready,
  output logic                   press_valid,
  output logic [1:0]             press_idx,
  output logic                   press_multi,
  output logic                   overrun,
  input  logic                   clear_overrun,
  output logic [NUM_BUTTONS-1:0] btn_level
);

  btn_vec_t    level_s;
  btn_vec_t    rise_s;
  logic        candidate_s;
  hold_state_t state_r;
  logic        valid_r;
  btn_idx_t    idx_r;
  logic        multi_r;
  logic        overrun_r;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .btn   (buttons[i]),
      .level (level_s[i]),
      .rise  (rise_s[i])
    );
  end

  assign candidate_s = enable && (rise_s != 4'b0000);

  // Single-entry event holding register plus sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= HOLD_EMPTY;
      valid_r   <= 1'b0;
      idx_r     <= 2'd0;
      multi_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      case (state_r)
        HOLD_EMPTY: begin
          if (candidate_s) begin
            state_r <= HOLD_FULL;
            valid_r <= 1'b1;
            idx_r   <= lowest_idx(rise_s);
            multi_r <= is_multi(rise_s);
          end else begin
            valid_r <= 1'b0;
          end
        end
        HOLD_FULL: begin
          if (press_ready && candidate_s) begin
            idx_r   <= lowest_idx(rise_s);
            multi_r <= is_multi(rise_s);
          end else if (press_ready) begin
            state_r <= HOLD_EMPTY;
            valid_r <= 1'b0;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= HOLD_EMPTY;
          valid_r <= 1'b0;
        end
      endcase

      if ((state_r == HOLD_FULL) && !press_ready && candidate_s) begin
        overrun_r <= 1'b1;
      end else if (clear_overrun) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign press_valid = valid_r;
  assign press_idx   = idx_r;
  assign press_multi = multi_r;
  assign overrun     = overrun_r;
  assign btn_level   = level_s;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_button_press_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       enable;
  logic       press_ready;
  logic       press_valid;
  logic [1:0] press_idx;
  logic       press_multi;
  logic       overrun;
  logic       clear_overrun;
  logic [3:0] btn_level;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  logic bounce_seen;

  button_press_decoder #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons       (buttons),
    .enable        (enable),
    .press_ready   (press_ready),
    .press_valid   (press_valid),
    .press_idx     (press_idx),
    .press_multi   (press_multi),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .btn_level     (btn_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {7'd0, press_valid}, 8'd0);
    chk({tag, "_idx"},   {6'd0, press_idx},   8'd0);
    chk({tag, "_multi"}, {7'd0, press_multi}, 8'd0);
    chk({tag, "_ovr"},   {7'd0, overrun},     8'd0);
    chk({tag, "_level"}, {4'd0, btn_level},   8'd0);
  endtask

  initial begin
    reset         = 1'b1;
    buttons       = 4'b0000;
    enable        = 1'b1;
    press_ready   = 1'b1;
    clear_overrun = 1'b0;
    tick(2);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Single press: visible after the 6th edge, gone after the 7th.
    buttons = 4'b0100;
    tick(5);
    chk("single_early_valid", {7'd0, press_valid}, 8'd0);
    chk("single_early_level", {4'd0, btn_level}, 8'd0);
    tick(1);
    chk("single_valid", {7'd0, press_valid}, 8'd1);
    chk("single_idx",   {6'd0, press_idx},   8'd2);
    chk("single_multi", {7'd0, press_multi}, 8'd0);
    chk("single_level", {4'd0, btn_level},   8'h04);
    tick(1);
    chk("single_drop_valid", {7'd0, press_valid}, 8'd0);
    buttons = 4'b0000;
    tick(8);
    chk("release_level", {4'd0, btn_level},   8'd0);
    chk("release_valid", {7'd0, press_valid}, 8'd0);

    // Bounce: 1,1,1,0 never stays high for four synchronized cycles.
    bounce_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      buttons = (c % 4 == 3) ? 4'b0000 : 4'b0001;
      tick(1);
      if (press_valid || (btn_level != 4'b0000)) bounce_seen = 1'b1;
    end
    buttons = 4'b0000;
    tick(6);
    chk("bounce_quiet", {7'd0, bounce_seen}, 8'd0);

    // Simultaneous press of buttons 1 and 3.
    buttons = 4'b1010;
    tick(6);
    chk("multi_valid", {7'd0, press_valid}, 8'd1);
    chk("multi_idx",   {6'd0, press_idx},   8'd1);
    chk("multi_multi", {7'd0, press_multi}, 8'd1);
    chk("multi_level", {4'd0, btn_level},   8'h0A);
    tick(1);
    chk("multi_once_a", {7'd0, press_valid}, 8'd0);
    tick(3);
    chk("multi_once_b", {7'd0, press_valid}, 8'd0);
    buttons = 4'b0000;
    tick(8);

    // Overrun: pending event on button 0, then button 3 pressed while stalled.
    press_ready = 1'b0;
    buttons = 4'b0001;
    tick(6);
    chk("ovr_first_valid", {7'd0, press_valid}, 8'd1);
    chk("ovr_first_idx",   {6'd0, press_idx},   8'd0);
    buttons = 4'b0000;
    tick(8);
    chk("ovr_hold_valid", {7'd0, press_valid}, 8'd1);
    chk("ovr_not_yet",    {7'd0, overrun},     8'd0);
    buttons = 4'b1000;
    tick(6);
    chk("ovr_set",        {7'd0, overrun},     8'd1);
    chk("ovr_kept_valid", {7'd0, press_valid}, 8'd1);
    chk("ovr_kept_idx",   {6'd0, press_idx},   8'd0);
    chk("ovr_level",      {4'd0, btn_level},   8'h08);
    press_ready = 1'b1;
    tick(1);
    chk("ovr_consumed", {7'd0, press_valid}, 8'd0);
    tick(3);
    chk("ovr_sticky",   {7'd0, overrun},     8'd1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("ovr_cleared",  {7'd0, overrun},     8'd0);
    buttons = 4'b0000;
    tick(8);

    // Enable gating: held button seen on the LEDs but never as an event.
    enable  = 1'b0;
    buttons = 4'b0010;
    tick(6);
    chk("gate_level", {4'd0, btn_level},   8'h02);
    chk("gate_valid", {7'd0, press_valid}, 8'd0);
    enable = 1'b1;
    tick(3);
    chk("gate_held_valid", {7'd0, press_valid}, 8'd0);
    buttons = 4'b0000;
    tick(8);
    buttons = 4'b0010;
    tick(6);
    chk("gate_repress_valid", {7'd0, press_valid}, 8'd1);
    chk("gate_repress_idx",   {6'd0, press_idx},   8'd1);
    buttons = 4'b0000;
    tick(8);

    // Reset mid-count: asynchronous clear, then full latency from release.
    buttons = 4'b0100;
    tick(3);
    reset = 1'b1;
    #2;
    chk_all_zero("rst_count");
    reset = 1'b0;
    tick(5);
    chk("rst_count_early", {7'd0, press_valid}, 8'd0);
    tick(1);
    chk("rst_count_valid", {7'd0, press_valid}, 8'd1);
    chk("rst_count_idx",   {6'd0, press_idx},   8'd2);

    // Reset while an event is pending, button still held.
    press_ready = 1'b0;
    tick(2);
    chk("rst_pend_valid", {7'd0, press_valid}, 8'd1);
    reset = 1'b1;
    #2;
    chk_all_zero("rst_pend");
    reset = 1'b0;
    press_ready = 1'b1;
    tick(5);
    chk("rst_pend_early", {7'd0, press_valid}, 8'd0);
    tick(1);
    chk("rst_pend_valid2", {7'd0, press_valid}, 8'd1);
    chk("rst_pend_idx",    {6'd0, press_idx},   8'd2);
    chk("rst_pend_level",  {4'd0, btn_level},   8'h04);
    tick(1);
    chk("rst_pend_once", {7'd0, press_valid}, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
